// File: rtl/sar_adc_n_bits_10.sv
// Ideal 10-bit successive-approximation ADC model.
// Conversion steps advance only on rising edges of the slow sys_clk strobe,
// detected in the clk domain. The result is resolved MSB-first against the
// value held at the start of the conversion. eoc pulses for one tick interval.
module sar_adc_n_bits_10 #(
    parameter int N_BITS       = 10,
    parameter int SAMPLE_TICKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sys_clk,
    input  logic              input_hold_digital,
    input  logic [N_BITS-1:0] input_voltage_real,
    output logic [N_BITS-1:0] output_result_digital,
    output logic              eoc
);

    localparam int CNT_W = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
    localparam int BIT_W = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TICKS - 1);
    localparam logic [BIT_W-1:0] BIT_MSB     = BIT_W'(N_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE,
        ST_WAIT
    } state_t;

    state_t            r_state;
    logic              r_sysClkQ;
    logic [N_BITS-1:0] r_sar;
    logic [N_BITS-1:0] r_vinHold;
    logic [N_BITS-1:0] r_result;
    logic [CNT_W-1:0]  r_sampleCnt;
    logic [BIT_W-1:0]  r_bit;
    logic              r_eoc;

    logic              w_tick;
    logic [CNT_W-1:0]  w_sampleNext;
    logic [N_BITS-1:0] w_trial;

    assign w_tick       = sys_clk & ~r_sysClkQ;
    assign w_sampleNext = r_sampleCnt + 1'b1;
    assign w_trial      = r_sar | (N_BITS'(1) << r_bit);

    assign output_result_digital = r_result;
    assign eoc                   = r_eoc;

    // Registered copy of the strobe, used to find its rising edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sysClkQ <= 1'b0;
        end else begin
            r_sysClkQ <= sys_clk;
        end
    end

    // Conversion FSM: acquire, resolve one bit per tick, publish, then wait for hold release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sar       <= '0;
            r_vinHold   <= '0;
            r_result    <= '0;
            r_sampleCnt <= '0;
            r_bit       <= '0;
            r_eoc       <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (input_hold_digital) begin
                        r_vinHold   <= input_voltage_real;
                        r_sar       <= '0;
                        r_sampleCnt <= '0;
                        r_state     <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_sampleCnt <= w_sampleNext;
                    if (w_sampleNext == SAMPLE_LAST) begin
                        r_bit   <= BIT_MSB;
                        r_state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (w_trial <= r_vinHold) begin
                        r_sar <= w_trial;
                    end
                    if (r_bit == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_bit <= r_bit - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_result <= r_sar;
                    r_eoc    <= 1'b1;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_eoc <= 1'b0;
                    if (!input_hold_digital) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_n_bits_10.sv
// Directed testbench for the ideal 10-bit SAR ADC model.
// Each tick is one sys_clk pulse spanning two clk cycles; outputs are sampled on
// the falling clk edge after the tick has been taken.
module tb_sar_adc_n_bits_10;

   logic       clk = 1'b0;
   logic       reset;
   logic       sysClk;
   logic       hold;
   logic [9:0] vin;
   logic [9:0] result;
   logic       eocOut;

   int checks   = 0;
   int failures = 0;

   sar_adc_n_bits_10 dut (
      .clk                   (clk),
      .reset                 (reset),
      .sys_clk               (sysClk),
      .input_hold_digital    (hold),
      .input_voltage_real    (vin),
      .output_result_digital (result),
      .eoc                   (eocOut)
   );

   // Free-running fast clock.
   always #5 clk = ~clk;

   // Issue one tick with the given reset/hold/input levels, then settle.
   task automatic applyStimulus(input logic rst, input logic h, input logic [9:0] v);
      @(negedge clk);
      reset  = rst;
      hold   = h;
      vin    = v;
      sysClk = 1'b1;
      @(negedge clk);
      sysClk = 1'b0;
      @(negedge clk);
   endtask

   // Compare eoc and the published result against hand-computed values.
   task automatic checkOutput(input string tag, input logic expEoc, input logic [9:0] expRes);
      checks++;
      assert (eocOut === expEoc) else begin
         failures++;
         $error("FAIL %s eoc: observed %0b expected %0b", tag, eocOut, expEoc);
      end
      checks++;
      assert (result === expRes) else begin
         failures++;
         $error("FAIL %s result: observed 0x%03h expected 0x%03h", tag, result, expRes);
      end
   endtask

   // One full conversion with hold high from T0, optional input change and strobe pause,
   // followed by a release tick that returns the converter to idle.
   task automatic runConversion(input logic [9:0] v0, input logic [9:0] vLate, input int changeAt,
                                input int pauseAt, input logic [9:0] prevRes,
                                input logic [9:0] expRes, input int extraHigh);
      int pulses;
      pulses = 0;
      for (int k = 0; k <= 18 + extraHigh; k++) begin
         if (k == pauseAt) begin
            repeat (30) @(negedge clk);
            checkOutput($sformatf("pause v0=%03h", v0), 1'b0, prevRes);
         end
         applyStimulus(1'b0, 1'b1, (k < changeAt) ? v0 : vLate);
         if (eocOut === 1'b1) pulses++;
         checkOutput($sformatf("conv v0=%03h T%0d", v0, k), (k == 18), (k >= 18) ? expRes : prevRes);
      end
      checks++;
      assert (pulses == 1) else begin
         failures++;
         $error("FAIL pulse count v0=%03h: observed %0d expected 1", v0, pulses);
      end
      applyStimulus(1'b0, 1'b0, vLate);
      checkOutput($sformatf("release v0=%03h", v0), 1'b0, expRes);
   endtask

   // Directed sequence of scenarios.
   initial begin
      reset  = 1'b1;
      sysClk = 1'b0;
      hold   = 1'b0;
      vin    = 10'h000;
      repeat (2) @(negedge clk);

      $display("[TB] reset for two ticks");
      applyStimulus(1'b1, 1'b0, 10'h000);
      applyStimulus(1'b1, 1'b0, 10'h000);
      checkOutput("reset", 1'b0, 10'h000);
      applyStimulus(1'b0, 1'b0, 10'h123);
      checkOutput("idle hold low", 1'b0, 10'h000);

      $display("[TB] 0x2A5 with hold high for 50 ticks after DONE");
      runConversion(10'h2A5, 10'h2A5, 100, -1, 10'h000, 10'h2A5, 50);

      $display("[TB] boundary inputs 0x000 and 0x3FF");
      runConversion(10'h000, 10'h000, 100, -1, 10'h2A5, 10'h000, 2);
      runConversion(10'h3FF, 10'h3FF, 100, -1, 10'h000, 10'h3FF, 2);

      $display("[TB] reset at T10 mid-conversion");
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b1, 10'h155);
         checkOutput($sformatf("pre-abort T%0d", k), 1'b0, 10'h3FF);
      end
      applyStimulus(1'b1, 1'b1, 10'h155);
      checkOutput("abort reset", 1'b0, 10'h000);
      runConversion(10'h155, 10'h155, 100, -1, 10'h000, 10'h155, 2);

      $display("[TB] input changes at T5");
      runConversion(10'h100, 10'h3C0, 5, -1, 10'h155, 10'h100, 2);

      $display("[TB] strobe frozen for 30 clk cycles before T12");
      runConversion(10'h0F3, 10'h0F3, 100, 12, 10'h100, 10'h0F3, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/sar_adc_n_bits_10.md
Name: sar_adc_n_bits_10

Overview:
- Ideal 10-bit successive-approximation ADC model.
- Samples a 10-bit unsigned code standing in for the analog input, resolves it MSB-first, and pulses eoc for one conversion tick when the result is published.
- All logic runs on clk.
- Conversion steps advance only on "ticks": rising edges of the slow sys_clk strobe from the system frequency divider, detected inside the clk domain.

Parameters:
- N_BITS, 10: resolution; fixed at 10 for this variant.
- SAMPLE_TICKS, 8: acquisition/settling ticks before bit resolution starts.

Ports:
- clk  input  1  sole clock; all registers update on its rising edge.
- reset  input  1  synchronous, active-high; overrides all other activity.
- sys_clk  input  1  slow conversion strobe, treated as data. tick = sys_clk & ~sys_clk_q, where sys_clk_q is a registered copy.
- input_hold_digital  input  1  track/hold request; a conversion starts on the first tick it is seen high in IDLE.
- input_voltage_real  input  10  unsigned input level, code 0..1023.
- output_result_digital  output  10  last completed conversion result.
- eoc  output  1  end-of-conversion; registered; high for exactly one tick interval.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, sar=0, vin_hold=0, output_result_digital=0, eoc=0, sys_clk_q=0, counters=0.
  - Any in-flight conversion is aborted; no eoc is produced for it.
- sys_clk_q <= sys_clk every non-reset clk edge. Nothing below changes on clk edges that are not ticks.
- Tick numbering: T0 is the tick on which IDLE sees input_hold_digital=1.
- IDLE:
  - Hold low: stay IDLE.
  - Hold high (T0): vin_hold <= input_voltage_real, sar <= 0, sample_cnt <= 0, state <= SAMPLE.
- SAMPLE, ticks T1..T7 (SAMPLE_TICKS-1 further ticks, 8 total including T0):
  - sample_cnt increments each tick.
  - When sample_cnt reaches SAMPLE_TICKS-1: bit <= 9, state <= CONVERT.
  - input_voltage_real is ignored after T0.
- CONVERT, ticks T8..T17, one bit per tick, MSB first:
  - trial = sar | (1<<bit).
  - sar <= (trial <= vin_hold) ? trial : sar, unsigned 10-bit compare.
  - bit decrements each tick; after bit 0 (T17), state <= DONE.
- DONE, tick T18:
  - output_result_digital <= sar; eoc <= 1; state <= WAIT.
  - Ideal model: result always equals vin_hold.
- WAIT, tick T19 onward:
  - eoc <= 0 on T19.
  - Remain in WAIT while input_hold_digital=1.
  - First tick with hold=0 returns to IDLE.
  - A new conversion therefore requires hold low for at least one tick and then high again.
- Timing contract:
  - eoc is high from the T18 update until the T19 update.
  - Counting ticks from T0 with a counter that increments on every tick where hold or eoc is high: eoc=1 exactly when that counter equals 19 (pre-update value).
  - eoc is never high at any other count while hold stays high.
- input_hold_digital dropping during SAMPLE or CONVERT is ignored; the conversion completes normally.
- output_result_digital holds its value between DONE events, and from reset until the first DONE it reads 0.
- Boundaries:
  - Input 0 gives result 0x000; input 1023 gives 0x3FF.
  - No wrap-around is possible, since trial never exceeds 0x3FF.
- Reset asserted on the same clk edge as a tick takes priority.
- sys_clk held static means no ticks, so state freezes.

Test Plan:
- Reset for 2 ticks, then hold=1 constantly, input 0x2A5 -> eoc low on T0..T18 samples, high only at T19, low thereafter; output_result_digital=0x2A5 from T19 on.
- Input 0x000 and input 0x3FF, each with a fresh hold pulse -> results 0x000 and 0x3FF; eoc pulse one tick wide, 19 ticks after T0.
- Hold kept high after DONE for 50 ticks -> exactly one eoc pulse; result stays stable.
- Reset asserted at T10 mid-CONVERT -> eoc never pulses, result reads 0, state IDLE. After reset releases with hold high, a full 19-tick conversion follows.
- input_voltage_real changed from 0x100 to 0x3C0 at T5 -> result 0x100, because only the T0 value is used.
- sys_clk held constant for 30 clk cycles mid-conversion -> no state or output change. Conversion resumes on the next sys_clk rising edge with the same total tick count.
